// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/bubble/flush controller.
package pipeline_ctrl_pkg;

    // Pipeline register indices (register k loads from stage k-1).
    localparam int unsigned STG_PC = 0;
    localparam int unsigned STG_ID = 1;
    localparam int unsigned STG_EX = 2;
    localparam int unsigned STG_MM = 3;
    localparam int unsigned STG_WB = 4;

    // Stall points: registers [p:0] hold, register p+1 takes a bubble.
    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_ID = 1;
    localparam int unsigned STALL_EX = 2;

    typedef enum logic {
        StRun,
        StFlush
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_load_scoreboard.sv
// Tracks in-flight load destinations and flags load-use hazards against the ID operands.
module load_scoreboard #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [LOAD_LAT-1:0] en,
    input  logic [LOAD_LAT-1:0] bubble,
    input  logic                id_is_load,
    input  logic [REG_AW-1:0]   id_reg_dst,
    input  logic [REG_AW-1:0]   id_reg_s,
    input  logic [REG_AW-1:0]   id_reg_t,
    input  logic                id_use_s,
    input  logic                id_use_t,
    output logic                hazard
);

    logic [LOAD_LAT-1:0] sb_v_q;
    logic [REG_AW-1:0]   sb_a_q  [LOAD_LAT];
    logic [LOAD_LAT-1:0] shift_v;
    logic [REG_AW-1:0]   shift_a [LOAD_LAT];

    // Value each entry takes when its pipeline register advances.
    always_comb begin
        shift_v    = '0;
        shift_v[0] = id_is_load && (id_reg_dst != '0);
        shift_a[0] = id_reg_dst;
        for (int i = 1; i < int'(LOAD_LAT); i++) begin
            shift_v[i] = sb_v_q[i-1];
            shift_a[i] = sb_a_q[i-1];
        end
    end

    // Shift chain follows the pipeline registers it shadows.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sb_v_q <= '0;
            for (int i = 0; i < int'(LOAD_LAT); i++) begin
                sb_a_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(LOAD_LAT); i++) begin
                if (en[i]) begin
                    sb_v_q[i] <= shift_v[i];
                    sb_a_q[i] <= shift_a[i];
                end else if (bubble[i]) begin
                    sb_v_q[i] <= 1'b0;
                end
            end
        end
    end

    // Hazard when any pending load writes a register the ID instruction reads; $zero is exempt.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(LOAD_LAT); i++) begin
            if (sb_v_q[i] &&
                ((id_use_s && (id_reg_s != '0) && (id_reg_s == sb_a_q[i])) ||
                 (id_use_t && (id_reg_t != '0) && (id_reg_t == sb_a_q[i])))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/bubble/flush controller for the in-order pipeline, with event counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 5,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned LOAD_LAT   = 1,
    parameter int unsigned FLUSH_HOLD = 0,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_AW-1:0]     id_reg_s,
    input  logic [REG_AW-1:0]     id_reg_t,
    input  logic                  id_use_s,
    input  logic                  id_use_t,
    input  logic                  id_is_load,
    input  logic [REG_AW-1:0]     id_reg_dst,
    input  logic                  ex_stall_req,
    input  logic                  ibus_wait,
    input  logic                  dbus_wait,
    input  logic                  exception_req,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_bubble,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int unsigned HOLD_W = (FLUSH_HOLD > 0) ? $clog2(FLUSH_HOLD + 1) : 1;

    ctrl_state_e       state_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic              hazard;
    logic              flush_rise;
    logic              stall_evt;

    function automatic logic [NUM_STAGES-1:0] en_mask(input int unsigned p);
        return {NUM_STAGES{1'b1}} << (p + 2);
    endfunction

    function automatic logic [NUM_STAGES-1:0] bub_mask(input int unsigned p);
        return NUM_STAGES'(1) << (p + 1);
    endfunction

    assign flush = !rst && (exception_req || (hold_q != '0));

    load_scoreboard #(
        .REG_AW   (REG_AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush),
        .en         (stage_en[STG_EX +: LOAD_LAT]),
        .bubble     (stage_bubble[STG_EX +: LOAD_LAT]),
        .id_is_load (id_is_load),
        .id_reg_dst (id_reg_dst),
        .id_reg_s   (id_reg_s),
        .id_reg_t   (id_reg_t),
        .id_use_s   (id_use_s),
        .id_use_t   (id_use_t),
        .hazard     (hazard)
    );

    // Priority mux: reset/flush run everything, then freeze, EX stall, load-use, fetch wait.
    always_comb begin
        stage_en     = '1;
        stage_bubble = '0;
        if (!rst && !flush) begin
            if (dbus_wait) begin
                stage_en = '0;
            end else if (ex_stall_req) begin
                stage_en     = en_mask(STALL_EX);
                stage_bubble = bub_mask(STALL_EX);
            end else if (hazard) begin
                stage_en     = en_mask(STALL_ID);
                stage_bubble = bub_mask(STALL_ID);
            end else if (ibus_wait) begin
                stage_en     = en_mask(STALL_PC);
                stage_bubble = bub_mask(STALL_PC);
            end
        end
    end

    // In StRun flush was low last cycle, so an exception here is a fresh flush edge.
    assign flush_rise = (state_q == StRun) && exception_req;
    assign stall_evt  = !flush && (stage_en != '1);

    // Flush FSM, hold counter and event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            hold_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (exception_req) begin
                hold_q <= HOLD_W'(FLUSH_HOLD);
            end else if (hold_q != '0) begin
                hold_q <= hold_q - HOLD_W'(1);
            end
            unique case (state_q)
                StRun:   if (exception_req) state_q <= StFlush;
                StFlush: if (!exception_req && (hold_q == '0)) state_q <= StRun;
                default: state_q <= StRun;
            endcase
            if (flush_rise) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (stall_evt)  stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
